// File: rtl/spin_pkg.sv
// spin_pkg: shared definitions for the spin XNOR random-number generator and its checker
package spin_pkg;
  localparam int RNG_W = 4;
  localparam logic [RNG_W-1:0] RNG_LOCKUP = 4'hF;
  localparam int RNG_PERIOD = 15;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} chk_state_t;
  function automatic logic [RNG_W-1:0] rng_next(input logic [RNG_W-1:0] x);
    return {x[2:0], ~(x[3] ^ x[2])};
  endfunction
endpackage

// File: rtl/spin_rng_checker_if.sv
// spin_rng_checker_if: sample stream into the checker and its health outputs
interface spin_rng_checker_if #(
  parameter int ERR_W = 16,
  parameter int PER_W = 5
);
  logic sample_valid;
  logic [spin_pkg::RNG_W-1:0] rand_in;
  logic clear_err;
  logic locked;
  logic err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [PER_W-1:0] period_len;
  logic stuck;
  modport master (
    output sample_valid, rand_in, clear_err,
    input  locked, err_pulse, err_count, period_len, stuck
  );
  modport slave (
    input  sample_valid, rand_in, clear_err,
    output locked, err_pulse, err_count, period_len, stuck
  );
endinterface

// File: rtl/spin_rng_checker.sv
// spin_rng_checker: syncs to the XNOR spin RNG, counts mispredictions, measures period, flags lock-up
module spin_rng_checker
  import spin_pkg::*;
#(
  parameter int LOCK_MATCHES = 4,
  parameter int LOSS_MISSES  = 3,
  parameter int ERR_W        = 16,
  parameter int PER_W        = 5
) (
  input logic clk,
  input logic reset,
  spin_rng_checker_if.slave bus
);
  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int NW = $clog2(LOSS_MISSES + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_MATCHES - 1);
  localparam logic [NW-1:0] MISS_LAST = NW'(LOSS_MISSES - 1);
  chk_state_t state_q, state_d;
  logic [RNG_W-1:0] pred_q, pred_d;
  logic [MW-1:0] match_q, match_d;
  logic [NW-1:0] miss_q, miss_d;
  logic [PER_W-1:0] per_q, per_d, plen_q, plen_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic seen_q, seen_d, pulse_q, pulse_d, stuck_q, stuck_d;
  logic hit, is_zero;
  assign hit = bus.rand_in == pred_q;
  assign is_zero = bus.rand_in == '0;
  // next state: hunt/verify reseed from the input, locked flywheels on its own prediction
  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    match_d = match_q;
    miss_d  = miss_q;
    per_d   = per_q;
    seen_d  = seen_q;
    plen_d  = plen_q;
    err_d   = err_q;
    stuck_d = stuck_q;
    pulse_d = 1'b0;
    if (bus.sample_valid) begin
      stuck_d = stuck_q | (bus.rand_in == RNG_LOCKUP);
      unique case (state_q)
        HUNT: begin
          pred_d  = rng_next(bus.rand_in);
          match_d = '0;
          state_d = VERIFY;
        end
        VERIFY: begin
          pred_d  = rng_next(bus.rand_in);
          match_d = hit ? match_q + 1'b1 : '0;
          if (hit && match_q == MATCH_LAST) begin
            state_d = LOCKED;
            seen_d  = 1'b0;
            miss_d  = '0;
          end
        end
        LOCKED: begin
          pred_d  = rng_next(pred_q);
          per_d   = is_zero ? '0 : (per_q == '1 ? per_q : per_q + 1'b1);
          seen_d  = seen_q | is_zero;
          plen_d  = (is_zero && seen_q) ? (per_q == '1 ? per_q : per_q + 1'b1) : plen_q;
          pulse_d = !hit;
          err_d   = (hit || err_q == '1) ? err_q : err_q + 1'b1;
          miss_d  = (hit || miss_q == MISS_LAST) ? '0 : miss_q + 1'b1;
          state_d = (!hit && miss_q == MISS_LAST) ? HUNT : LOCKED;
        end
        default: state_d = HUNT;
      endcase
    end
    if (bus.clear_err) begin
      err_d   = '0;
      stuck_d = 1'b0;
    end
  end
  // state and counter registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      pred_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      per_q   <= '0;
      seen_q  <= 1'b0;
      plen_q  <= '0;
      err_q   <= '0;
      stuck_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pred_q  <= pred_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      per_q   <= per_d;
      seen_q  <= seen_d;
      plen_q  <= plen_d;
      err_q   <= err_d;
      stuck_q <= stuck_d;
      pulse_q <= pulse_d;
    end
  end
  assign bus.locked     = state_q == LOCKED;
  assign bus.err_pulse  = pulse_q;
  assign bus.err_count  = err_q;
  assign bus.period_len = plen_q;
  assign bus.stuck      = stuck_q;
endmodule

// File: tb/tb_spin_rng_checker.sv
// tb_spin_rng_checker: randomized and directed check of spin_rng_checker against a sequence-table model
module tb_spin_rng_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  spin_rng_checker_if bus ();
  spin_rng_checker dut (.clk(clk), .reset(reset), .bus(bus));
  int total = 0, bad = 0;
  logic [3:0] seq [15] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                           4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
  int g = 0;
  int m_mode = 0, m_match = 0, m_miss = 0, m_err = 0, m_per = 0, m_plen = 0;
  logic [3:0] m_pred = 4'h0;
  bit m_seen = 0, m_stuck = 0, m_pulse = 0;
  function automatic logic [3:0] tnext(input logic [3:0] x);
    for (int i = 0; i < 15; i++)
      if (seq[i] == x) return seq[(i + 1) % 15];
    return 4'hF;
  endfunction
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_match = 0; m_miss = 0; m_err = 0; m_per = 0; m_plen = 0;
    m_pred = 4'h0; m_seen = 0; m_stuck = 0; m_pulse = 0;
  endtask
  task automatic model(input bit v, input logic [3:0] r, input bit c);
    m_pulse = 0;
    if (v) begin
      if (r == 4'hF) m_stuck = 1;
      if (m_mode == 0) begin
        m_pred = tnext(r); m_match = 0; m_mode = 1;
      end else if (m_mode == 1) begin
        m_match = (r == m_pred) ? m_match + 1 : 0;
        m_pred = tnext(r);
        if (m_match == 4) begin m_mode = 2; m_seen = 0; m_miss = 0; end
      end else begin
        if (r == 4'h0) begin
          if (m_seen) m_plen = (m_per + 1 > 31) ? 31 : m_per + 1;
          m_per = 0; m_seen = 1;
        end else m_per = (m_per + 1 > 31) ? 31 : m_per + 1;
        if (r != m_pred) begin
          m_pulse = 1;
          m_err = (m_err == 65535) ? m_err : m_err + 1;
          m_miss++;
          if (m_miss == 3) begin m_mode = 0; m_miss = 0; end
        end else m_miss = 0;
        m_pred = tnext(m_pred);
      end
    end
    if (c) begin m_err = 0; m_stuck = 0; end
  endtask
  always @(negedge clk) if (!reset) begin
    chk("locked", bus.locked, m_mode == 2);
    chk("err_pulse", bus.err_pulse, m_pulse);
    chk("err_count", bus.err_count, m_err);
    chk("period_len", bus.period_len, m_plen);
    chk("stuck", bus.stuck, m_stuck);
  end
  task automatic step(input bit v, input logic [3:0] r, input bit c);
    bus.sample_valid = v; bus.rand_in = r; bus.clear_err = c;
    @(posedge clk); #1;
    model(v, r, c);
    bus.sample_valid = 1'b0; bus.clear_err = 1'b0;
  endtask
  task automatic send_true();
    step(1, seq[g], 0);
    g = (g + 1) % 15;
  endtask
  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 chk("async_locked", bus.locked, 0);
    @(posedge clk); #1 reset = 1'b0;
  endtask
  task automatic lock();
    g = 0;
    repeat (5) send_true();
  endtask
  function automatic logic [3:0] wrong_of(input logic [3:0] p);
    return (p == 4'h0) ? 4'h1 : 4'h0;
  endfunction
  initial begin
    bus.sample_valid = 1'b0; bus.rand_in = 4'h0; bus.clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_locked", bus.locked, 0);
    chk("rst_err", bus.err_count, 0);
    chk("rst_plen", bus.period_len, 0);
    g = 0;
    repeat (4) send_true();
    chk("lock_after_7", bus.locked, 0);
    send_true();
    chk("lock_after_E", bus.locked, 1);
    send_true();
    chk("lock_after_D", bus.locked, 1);
    chk("lock_err", bus.err_count, 0);
    repeat (10) send_true();
    chk("plen_first0", bus.period_len, 0);
    repeat (15) send_true();
    chk("plen_15", bus.period_len, 15);
    chk("plen_err", bus.err_count, 0);
    do_reset();
    lock();
    send_true(); send_true();
    step(1, 4'h5, 0); g = (g + 1) % 15;
    chk("inj_pulse", bus.err_pulse, 1);
    chk("inj_err", bus.err_count, 1);
    chk("inj_locked", bus.locked, 1);
    repeat (5) send_true();
    chk("inj_err_after", bus.err_count, 1);
    chk("inj_locked_after", bus.locked, 1);
    do_reset();
    lock();
    step(1, wrong_of(m_pred), 0);
    step(1, wrong_of(m_pred), 0);
    chk("miss2_locked", bus.locked, 1);
    step(1, wrong_of(m_pred), 0);
    chk("miss3_locked", bus.locked, 0);
    chk("miss3_err", bus.err_count, 3);
    repeat (4) send_true();
    chk("relock4", bus.locked, 0);
    send_true();
    chk("relock5", bus.locked, 1);
    do_reset();
    repeat (3) step(1, 4'hF, 0);
    chk("stuck_set", bus.stuck, 1);
    step(0, 4'h0, 1);
    chk("stuck_clr", bus.stuck, 0);
    chk("stuck_clr_err", bus.err_count, 0);
    step(1, 4'hF, 1);
    chk("stuck_clr_wins", bus.stuck, 0);
    do_reset();
    lock();
    step(1, wrong_of(m_pred), 1);
    chk("clr_pulse", bus.err_pulse, 1);
    chk("clr_err", bus.err_count, 0);
    chk("clr_locked", bus.locked, 1);
    do_reset();
    g = 0;
    for (int i = 0; i < 4000; i++) begin
      int k;
      k = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) step(0, 4'($urandom), $urandom_range(0, 39) == 0);
      else if (k < 88) begin
        step(1, seq[g], $urandom_range(0, 39) == 0);
        g = (g + 1) % 15;
      end else if (k < 97) step(1, 4'($urandom), $urandom_range(0, 39) == 0);
      else step(1, 4'hF, 0);
      if ($urandom_range(0, 599) == 0) do_reset();
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
